button_pulser: RTL and testbench
================================

Name: button_pulser

Overview:
- Front end that produces the single-cycle move/select strobes consumed by the game FSM (BtnL, BtnR, BtnU, BtnD, BtnC).
- Synchronizes raw pushbutton levels, debounces each one, and emits exactly one clock-wide pulse per qualified press.
- Optional per-button auto-repeat while a button is held, so cursor buttons can sweep the board.
- Sits between the board pins and the game core; one instance serves all buttons.

Parameters:
- N_BTN, 5, number of buttons; index 0..4 = L, R, U, D, C.
- DB_CYCLES, 1000000, number of consecutive stable cycles required to qualify a press or a release (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000, held cycles after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 20000000, cycles between auto-repeat pulses.
- REPEAT_MASK, 5'b00011, per-button auto-repeat enable; default enables L and R only.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- BtnRaw  input  N_BTN  raw, unsynchronized pushbutton levels; 1 = pressed.
- BtnPulse  output  N_BTN  one-cycle strobe per qualified press or repeat.
- BtnLevel  output  N_BTN  debounced level; 1 from the first pulse until the release is qualified.
- Busy  output  1  OR of all buttons not in INI (used by the game to ignore ambiguous input).

Behaviour:
- Clock and reset: one clock. Reset (low) asynchronously clears the synchronizer flops, all counters, BtnPulse, BtnLevel and Busy to 0, and forces every per-button FSM to INI.
- Synchronizer: 2-flop synchronizer per bit. `s` denotes the synchronized level.
- Per-button FSM, one-hot 5-bit encoding (INI=00001, WQ=00010, SCEN=00100, CCR=01000, WFCR=10000):
  - INI: counter = 0. If s=1, go to WQ.
  - WQ: counter increments while s=1. If s=0, return to INI with counter cleared (bounce). If s=1 and counter = DB_CYCLES-1, go to SCEN.
  - SCEN: BtnPulse[i]=1 for exactly this cycle. Set BtnLevel[i]=1, clear counter, go to CCR unconditionally.
  - CCR (held): counter increments while s=1.
    - If REPEAT_MASK[i] is set and counter reaches REPEAT_DELAY-1 for the first repeat, or REPEAT_PERIOD-1 for later repeats: go to SCEN, which emits the repeat pulse.
    - A repeat flag selects the terminal value; the flag is cleared on exit to INI.
    - If s=0, clear counter and go to WFCR.
  - WFCR (release qualify): counter increments while s=0.
    - If s=1, go to CCR with counter cleared; no pulse is emitted and the repeat delay restarts.
    - If counter = DB_CYCLES-1, clear BtnLevel[i] and go to INI.
- Latency: raw rising edge to BtnPulse = 2 (sync) + DB_CYCLES + 1 cycles, given clean input.
- Counter width is $clog2 of the largest of DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD, plus 1. Counters saturate and never wrap.
- Buttons are fully independent. Simultaneous presses yield simultaneous pulses; no arbitration.
- A button held through reset deassertion is treated as a fresh press. It pulses once after the qualify time.
- Busy is combinational: the OR of all per-button "state != INI".
- At most one pulse per SCEN entry. BtnPulse is never high on two consecutive cycles for the same bit.

Decomposition:
- Shared package `btn_pkg` holds:
  - state localparams INI, WQ, SCEN, CCR, WFCR;
  - button index constants BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3, BTN_C=4;
  - N_BTN default.
- Sub-module `btn_debounce_one`: synchronizer, one FSM and one counter. It takes the timing parameters and a REPEAT_EN bit.
- `button_pulser` generates N_BTN instances and forms Busy.

Test Plan:
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press: BtnRaw[0] rises and is held for 20 cycles, then released. Required: one BtnPulse[0], 7 cycles after the edge. BtnLevel[0] stays 1 until 4 stable low cycles after the synchronized release. No other bits toggle.
2. Bounce: BtnRaw[2] toggles 1,0,1,0 on single cycles, then holds 1. Required: no pulse during the bounce, exactly one pulse 7 cycles after the final rise. U has no repeat, so no further pulses while held.
3. Auto-repeat: BtnRaw[1] is held 40 cycles. Required: first pulse at cycle 7, then pulses 11, 15, 19, … cycles after the first (SCEN counted). Pulses stop once released.
4. Release glitch: Btn C is held, then a 2-cycle low glitch is applied. Required: no second pulse, and BtnLevel[4] stays 1 throughout.
5. Simultaneous: BtnRaw[1] and BtnRaw[3] rise in the same cycle. Required: BtnPulse = 5'b01010 in a single cycle.
6. Reset mid-operation: Reset is pulled low while in CCR with BtnRaw[0] still held. Required: all outputs are 0 immediately (asynchronously). After Reset returns high, exactly one pulse occurs 7 cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton front end: per-button FSM
// state encoding, button index map and counter sizing helper.
package btn_pkg;

  localparam int unsigned N_BTN_DEF = 5;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_C = 4;

  typedef enum logic [4:0] {
    INI  = 5'b00001,
    WQ   = 5'b00010,
    SCEN = 5'b00100,
    CCR  = 5'b01000,
    WFCR = 5'b10000
  } btn_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_pulser_if.sv
// Button bundle between the board pins and the game core.
interface button_pulser_if #(
  parameter int unsigned N_BTN = 5
);
  logic [N_BTN-1:0] BtnRaw;
  logic [N_BTN-1:0] BtnPulse;
  logic [N_BTN-1:0] BtnLevel;
  logic             Busy;

  modport master (output BtnRaw, input BtnPulse, input BtnLevel, input Busy);
  modport slave  (input BtnRaw, output BtnPulse, output BtnLevel, output Busy);
endinterface

// File: rtl/btn_debounce_one.sv
// One button: 2-flop synchronizer, debounce/repeat FSM and a saturating counter.
// Pulse and level are registered and asserted on the same edge that enters SCEN.
module btn_debounce_one
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 20000000,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pulse_o,
  output logic level_o,
  output logic busy_o
);

  localparam int unsigned CntW = $clog2(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CntW-1:0] DbLast     = CntW'(DB_CYCLES - 1);
  localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);

  logic [1:0]      sync_q;
  logic            s;
  btn_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc, rpt_last;
  logic            rep_q, rep_d;
  logic            pulse_q, pulse_d;
  logic            level_q, level_d;

  assign s        = sync_q[1];
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  // First repeat waits the long delay, later ones use the short period.
  assign rpt_last = rep_q ? PeriodLast : DelayLast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    level_d = level_q;
    unique case (state_q)
      INI: begin
        cnt_d = '0;
        if (s) state_d = WQ;
      end
      WQ: begin
        if (!s) begin
          state_d = INI;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d = SCEN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SCEN: begin
        cnt_d   = '0;
        state_d = CCR;
      end
      CCR: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = WFCR;
        end else if (REPEAT_EN && (cnt_q == rpt_last)) begin
          state_d = SCEN;
          rep_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WFCR: begin
        if (s) begin
          // Glitch during release: back to held, repeat delay starts over.
          state_d = CCR;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else if (cnt_q == DbLast) begin
          state_d = INI;
          cnt_d   = '0;
          rep_d   = 1'b0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = INI;
        cnt_d   = '0;
        rep_d   = 1'b0;
        level_d = 1'b0;
      end
    endcase
    if (state_d == SCEN) level_d = 1'b1;
    pulse_d = (state_d == SCEN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= INI;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;
  assign busy_o  = (state_q != INI);

endmodule

// File: rtl/button_pulser.sv
// Pushbutton front end: one independent debounce/repeat channel per button,
// with Busy flagging any button that is not idle.
module button_pulser
  import btn_pkg::*;
#(
  parameter int unsigned      N_BTN         = N_BTN_DEF,
  parameter int unsigned      DB_CYCLES     = 1000000,
  parameter int unsigned      REPEAT_DELAY  = 50000000,
  parameter int unsigned      REPEAT_PERIOD = 20000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'((1 << BTN_L) | (1 << BTN_R))
) (
  input  logic            Clk,
  input  logic            Reset,
  button_pulser_if.slave  bus
);

  logic [N_BTN-1:0] pulse;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] busy;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_one #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (REPEAT_MASK[i])
    ) u_btn (
      .clk_i   (Clk),
      .rst_ni  (Reset),
      .raw_i   (bus.BtnRaw[i]),
      .pulse_o (pulse[i]),
      .level_o (level[i]),
      .busy_o  (busy[i])
    );
  end

  assign bus.BtnPulse = pulse;
  assign bus.BtnLevel = level;
  assign bus.Busy     = |busy;

endmodule

// File: tb/tb_button_pulser.sv
// Scoreboard bench for button_pulser with short timing (DB=4, delay=10, period=3).
module tb_button_pulser;
  import btn_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  vec;
  } exp_t;

  logic        Clk;
  logic        Reset;
  int unsigned cyc;
  int          checks;
  int          errors;
  exp_t        exp_q[$];

  button_pulser_if #(.N_BTN(5)) bus ();

  button_pulser #(
    .N_BTN         (5),
    .DB_CYCLES     (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3),
    .REPEAT_MASK   (5'b00011)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_pulse(input int unsigned c, input logic [4:0] v);
    exp_t item;
    item.cyc = c;
    item.vec = v;
    exp_q.push_back(item);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the queue head.
  initial begin
    exp_t item;
    forever begin
      @(negedge Clk);
      if (bus.BtnPulse !== 5'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got %b at cycle %0d, required none",
                   bus.BtnPulse, cyc);
        end else begin
          item = exp_q.pop_front();
          if (item.cyc != cyc || item.vec !== bus.BtnPulse) begin
            errors++;
            $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                     bus.BtnPulse, cyc, item.vec, item.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        item = exp_q.pop_front();
        $display("FAIL missed_pulse: got none by cycle %0d, required %b at cycle %0d",
                 cyc, item.vec, item.cyc);
      end
    end
  end

  initial begin
    int unsigned e;
    int unsigned r;
    checks      = 0;
    errors      = 0;
    Reset       = 1'b0;
    bus.BtnRaw  = '0;
    repeat (3) step();
    check("reset_pulse", bus.BtnPulse, 5'b0);
    check("reset_level", bus.BtnLevel, 5'b0);
    check("reset_busy", {4'b0, bus.Busy}, 5'b0);
    Reset = 1'b1;
    repeat (3) step();

    // 1: clean press on L, released before any repeat could fire
    bus.BtnRaw[BTN_L] = 1'b1;
    e = cyc;
    expect_pulse(e + 7, 5'b00001);
    repeat (6) step();
    check("t1_level_pre", bus.BtnLevel, 5'b00000);
    step();
    check("t1_level_on", bus.BtnLevel, 5'b00001);
    repeat (7) step();
    bus.BtnRaw[BTN_L] = 1'b0;
    r = cyc;
    repeat (6) step();
    check("t1_level_hold", bus.BtnLevel, 5'b00001);
    step();
    check("t1_level_off", bus.BtnLevel, 5'b00000);
    check("t1_busy_off", {4'b0, bus.Busy}, 5'b0);
    repeat (3) step();

    // 2: bounce on U, then a steady hold with no repeat
    bus.BtnRaw[BTN_U] = 1'b1; step();
    bus.BtnRaw[BTN_U] = 1'b0; step();
    bus.BtnRaw[BTN_U] = 1'b1; step();
    bus.BtnRaw[BTN_U] = 1'b0; step();
    bus.BtnRaw[BTN_U] = 1'b1;
    e = cyc;
    expect_pulse(e + 7, 5'b00100);
    repeat (25) step();
    check("t2_level_held", bus.BtnLevel, 5'b00100);
    bus.BtnRaw[BTN_U] = 1'b0;
    repeat (7) step();
    check("t2_level_off", bus.BtnLevel, 5'b00000);
    repeat (3) step();

    // 3: auto-repeat on R held 40 cycles
    bus.BtnRaw[BTN_R] = 1'b1;
    e = cyc;
    expect_pulse(e + 7, 5'b00010);
    expect_pulse(e + 18, 5'b00010);
    expect_pulse(e + 22, 5'b00010);
    expect_pulse(e + 26, 5'b00010);
    expect_pulse(e + 30, 5'b00010);
    expect_pulse(e + 34, 5'b00010);
    expect_pulse(e + 38, 5'b00010);
    expect_pulse(e + 42, 5'b00010);
    repeat (40) step();
    bus.BtnRaw[BTN_R] = 1'b0;
    repeat (12) step();
    check("t3_level_off", bus.BtnLevel, 5'b00000);
    check("t3_busy_off", {4'b0, bus.Busy}, 5'b0);
    repeat (3) step();

    // 4: C held, 2-cycle low glitch must not re-pulse nor drop the level
    bus.BtnRaw[BTN_C] = 1'b1;
    e = cyc;
    expect_pulse(e + 7, 5'b10000);
    repeat (12) step();
    check("t4_level_held", bus.BtnLevel, 5'b10000);
    bus.BtnRaw[BTN_C] = 1'b0;
    step();
    check("t4_level_glitch", bus.BtnLevel, 5'b10000);
    step();
    bus.BtnRaw[BTN_C] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t4_level_glitch", bus.BtnLevel, 5'b10000);
    end
    bus.BtnRaw[BTN_C] = 1'b0;
    repeat (8) step();
    check("t4_level_off", bus.BtnLevel, 5'b00000);
    repeat (3) step();

    // 5: R and D rise together
    bus.BtnRaw[BTN_R] = 1'b1;
    bus.BtnRaw[BTN_D] = 1'b1;
    e = cyc;
    expect_pulse(e + 7, 5'b01010);
    repeat (8) step();
    check("t5_level_on", bus.BtnLevel, 5'b01010);
    check("t5_busy_on", {4'b0, bus.Busy}, 5'b00001);
    repeat (2) step();
    bus.BtnRaw[BTN_R] = 1'b0;
    bus.BtnRaw[BTN_D] = 1'b0;
    repeat (8) step();
    check("t5_level_off", bus.BtnLevel, 5'b00000);
    check("t5_busy_off", {4'b0, bus.Busy}, 5'b0);
    repeat (3) step();

    // 6: reset mid-hold; held button is a fresh press afterwards
    bus.BtnRaw[BTN_L] = 1'b1;
    e = cyc;
    expect_pulse(e + 7, 5'b00001);
    repeat (10) step();
    check("t6_level_pre", bus.BtnLevel, 5'b00001);
    #2;
    Reset = 1'b0;
    #1;
    check("t6_async_pulse", bus.BtnPulse, 5'b0);
    check("t6_async_level", bus.BtnLevel, 5'b0);
    check("t6_async_busy", {4'b0, bus.Busy}, 5'b0);
    step();
    Reset = 1'b1;
    e = cyc;
    expect_pulse(e + 7, 5'b00001);
    repeat (10) step();
    check("t6_level_after", bus.BtnLevel, 5'b00001);
    bus.BtnRaw[BTN_L] = 1'b0;
    repeat (10) step();
    check("t6_level_off", bus.BtnLevel, 5'b00000);

    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pulses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
